mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped I/O controller for the multicycle RISC-V system; replaces the ad-hoc LED/HEX write logic in the top level.
- Decodes the I/O window (addr[8]=1), holds LED and HEX output registers, synchronises and debounces KEY/SW inputs, latches key-press events, and drives active-low 7-segment outputs.
- Read data mux is combinational, matching the RAM read timing the CPU already expects.

Parameters:
- NUM_LEDS, 10, LED register width (1..32).
- NUM_HEX, 6, number of 4-bit hex digits (1..8).
- NUM_KEYS, 4, push-button count (1..8).
- NUM_SW, 10, slide-switch count (1..32).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a key change (>=1, counter width $clog2(DEBOUNCE_CYCLES+1)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  CPU byte address.
- writedata  in  32  CPU store data.
- memwrite  in  1  CPU store strobe.
- readdata  out  32  I/O read data (valid when io_sel=1).
- io_sel  out  1  addr[8]; top level muxes readdata between RAM and this block.
- key_n  in  NUM_KEYS  raw buttons, active-low (0 = pressed), asynchronous.
- sw  in  NUM_SW  raw switches, asynchronous.
- ledr  out  NUM_LEDS  LED register.
- hex_digits  out  NUM_HEX*4  HEX register, digit i at [4i+3:4i].
- hex_seg_n  out  NUM_HEX*7  active-low segments {g,f,e,d,c,b,a} per digit, digit i at [7i+6:7i].

Behaviour:
- Address map (one-hot bits, I/O window addr[8]=1): LEDS bit2 0x104 RW; HEX bit3 0x108 RW; KEY bit4 0x110 RO (debounced pressed state, 1 = pressed); SW bit5 0x120 RO (synchronised); KEY_EDGE bit6 0x140 R/W1C.
- Write: when memwrite & addr[8], every register whose bit is set is written in the same cycle (multi-hot allowed); writes to RO registers ignored; upper writedata bits above register width dropped.
- Read: lowest set bit among addr[6:2] selects; no bit set -> 0; values zero-extended to 32; reads have no side effects.
- Input sync: key_n and sw each pass 2 flops; value visible 2 cycles after input change.
- Debounce per key: stable bit s, counter c. If synced pressed != s, c increments; when c reaches DEBOUNCE_CYCLES-1 and still differs, s toggles, c=0. If synced == s, c=0. Glitch shorter than DEBOUNCE_CYCLES cycles never changes s.
- Press latency: KEY bit rises 2+DEBOUNCE_CYCLES cycles after key_n falls.
- KEY_EDGE[i] sets in the cycle s[i] goes 0->1; release does not set it. Write with writedata[i]=1 clears bit i; simultaneous set and clear -> set wins.
- hex_seg_n: combinational 0-F decode of hex_digits (0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110).
- Reset (reset=0, asynchronous): ledr=0, hex_digits=0 (hex_seg_n shows "0" on all digits), sync flops = released/0, s=0, c=0, KEY_EDGE=0, irq=0. Reset asserted mid-debounce discards the count; no edge is reported after release unless a full new debounce completes.

Optional Feature:
- Macro MMIO_IO_IRQ_EN.
- Defined: adds output irq (1 bit) and register IRQ_MASK at bit7 0x180 RW (NUM_KEYS bits, reset 0). irq is registered: irq <= |(KEY_EDGE & IRQ_MASK), one cycle after the contributing state; clearing the edge drops irq the cycle after the W1C write. Address 0x180 participates in read priority after bit6.
- Not defined: no irq port, bit7 decodes nothing, reads of 0x180 return 0.

Test Plan:
- Reset then write 0x3FF to 0x104 and 0x00ABCDEF to 0x108 -> ledr=0x3FF, hex_digits=0xABCDEF, digit0 hex_seg_n=7'b0001110; read back returns 0x3FF and 0xABCDEF.
- Write 0x155 to 0x10C (LEDS+HEX) -> ledr=0x155, hex_digits=0x000155; read 0x10C returns LEDS (0x155).
- Drive key_n[1]=0 steady -> read 0x110 = 0x2 exactly 6 cycles later (DEBOUNCE_CYCLES=4), 0x140 = 0x2; 3-cycle glitch on key_n[0] -> KEY and KEY_EDGE bit0 stay 0.
- Write 0x2 to 0x140 -> KEY_EDGE=0; release and re-press key1 with W1C in the setting cycle -> KEY_EDGE bit1 remains 1.
- sw=0x2A5 -> read 0x120 = 0x2A5 from 2 cycles later; write to 0x120 has no effect; assert reset mid-sequence -> all outputs at reset values immediately, without a clock edge.
- With MMIO_IO_IRQ_EN: IRQ_MASK=0x1, press key0 -> irq=1 one cycle after KEY_EDGE[0] sets; write 0x1 to 0x140 -> irq=0 next cycle; key2 press with mask 0x1 -> irq stays 0.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped LED/HEX/KEY/SW controller; MMIO_IO_IRQ_EN adds IRQ_MASK and irq
module mmio_io_ctrl #(
  parameter int NUM_LEDS        = 10,
  parameter int NUM_HEX         = 6,
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           writedata,
  input  logic                  memwrite,
  output logic [31:0]           readdata,
  output logic                  io_sel,
  input  logic [NUM_KEYS-1:0]   key_n,
  input  logic [NUM_SW-1:0]     sw,
  output logic [NUM_LEDS-1:0]   ledr,
  output logic [NUM_HEX*4-1:0]  hex_digits,
  output logic [NUM_HEX*7-1:0]  hex_seg_n
`ifdef MMIO_IO_IRQ_EN
  ,
  output logic                  irq
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic                         wr;
  logic [NUM_KEYS-1:0]          key_m, key_y, key_s, s_nxt, done, key_edge, edge_clr, edge_nxt;
  logic [NUM_SW-1:0]            sw_m, sw_y;
  logic [NUM_KEYS-1:0][CW-1:0]  cnt, cnt_nxt;
  logic [31:0]                  rd_hi;
  logic                         unused_bits;
  assign io_sel      = addr[8];
  assign wr          = memwrite & addr[8];
  assign unused_bits = ^{addr[31:9], addr[7], addr[1:0], writedata};
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      done[k]    = (~key_y[k] != key_s[k]) && (cnt[k] == CW'(DEBOUNCE_CYCLES - 1));
      cnt_nxt[k] = ((~key_y[k] != key_s[k]) && !done[k]) ? cnt[k] + 1'b1 : '0;
    end
    s_nxt    = key_s ^ done;
    edge_clr = (wr & addr[6]) ? writedata[NUM_KEYS-1:0] : '0;
    edge_nxt = (key_edge & ~edge_clr) | (s_nxt & ~key_s);
  end
  // key sync flops reset to the released level so reset never looks like a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_m      <= '1;
      key_y      <= '1;
      sw_m       <= '0;
      sw_y       <= '0;
      key_s      <= '0;
      cnt        <= '0;
      key_edge   <= '0;
      ledr       <= '0;
      hex_digits <= '0;
    end else begin
      key_m    <= key_n;
      key_y    <= key_m;
      sw_m     <= sw;
      sw_y     <= sw_m;
      key_s    <= s_nxt;
      cnt      <= cnt_nxt;
      key_edge <= edge_nxt;
      if (wr & addr[2]) ledr <= writedata[NUM_LEDS-1:0];
      if (wr & addr[3]) hex_digits <= writedata[NUM_HEX*4-1:0];
    end
  end
`ifdef MMIO_IO_IRQ_EN
  logic [NUM_KEYS-1:0] irq_mask;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr & addr[7]) irq_mask <= writedata[NUM_KEYS-1:0];
      irq <= |(key_edge & irq_mask);
    end
  end
  assign rd_hi = addr[7] ? 32'(irq_mask) : '0;
`else
  assign rd_hi = '0;
`endif
  assign readdata = addr[2] ? 32'(ledr) :
                    addr[3] ? 32'(hex_digits) :
                    addr[4] ? 32'(key_s) :
                    addr[5] ? 32'(sw_y) :
                    addr[6] ? 32'(key_edge) : rd_hi;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction
  for (genvar i = 0; i < NUM_HEX; i++) begin : g_seg
    assign hex_seg_n[7*i +: 7] = seg7(hex_digits[4*i +: 4]);
  end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: table-driven register tests plus key/switch/reset/irq sequences
module tb_mmio_io_ctrl;
  logic        clk, reset, memwrite, io_sel;
  logic [31:0] addr, writedata, readdata;
  logic [3:0]  key_n;
  logic [9:0]  sw, ledr;
  logic [23:0] hex_digits;
  logic [41:0] hex_seg_n;
`ifdef MMIO_IO_IRQ_EN
  logic        irq;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  mmio_io_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .writedata(writedata), .memwrite(memwrite),
    .readdata(readdata), .io_sel(io_sel), .key_n(key_n), .sw(sw), .ledr(ledr),
    .hex_digits(hex_digits), .hex_seg_n(hex_seg_n)
`ifdef MMIO_IO_IRQ_EN
    , .irq(irq)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic [9:0]  led;
    logic [23:0] hex;
  } vec_t;
  vec_t tv[10];
  logic [6:0] seg_tab[16];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, act, exp);
    end
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    addr = a;
    memwrite = 0;
    sb_q.push_back(e);
    #1;
    chk(n, 64'(readdata), 64'(sb_q.pop_front()));
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    writedata = d;
    memwrite = 1;
    @(posedge clk);
    #1 memwrite = 0;
    @(negedge clk);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    tv[0] = '{1, 32'h104, 32'h000003FF, 32'h3FF,    10'h3FF, 24'h000000};
    tv[1] = '{1, 32'h108, 32'h00ABCDEF, 32'hABCDEF, 10'h3FF, 24'hABCDEF};
    tv[2] = '{1, 32'h10C, 32'h00000155, 32'h155,    10'h155, 24'h000155};
    tv[3] = '{1, 32'h108, 32'hFFFFFFFF, 32'hFFFFFF, 10'h155, 24'hFFFFFF};
    tv[4] = '{1, 32'h104, 32'hFFFFFC01, 32'h001,    10'h001, 24'hFFFFFF};
    tv[5] = '{0, 32'h100, 32'h0,        32'h0,      10'h001, 24'hFFFFFF};
    tv[6] = '{1, 32'h120, 32'h000003FF, 32'h0,      10'h001, 24'hFFFFFF};
    tv[7] = '{1, 32'h110, 32'h0000000F, 32'h0,      10'h001, 24'hFFFFFF};
    tv[8] = '{0, 32'h180, 32'h0,        32'h0,      10'h001, 24'hFFFFFF};
    tv[9] = '{1, 32'h1FC, 32'h00000012, 32'h12,     10'h012, 24'h000012};
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    clk = 0; reset = 1; addr = 0; writedata = 0; memwrite = 0; key_n = '1; sw = '0;
    #1 reset = 0;
    cyc(2);
    chk("rst_led", 64'(ledr), 0);
    chk("rst_hex", 64'(hex_digits), 0);
    chk("rst_seg", 64'(hex_seg_n), 64'({6{7'b1000000}}));
    rd(32'h110, 0, "rst_key");
    rd(32'h140, 0, "rst_edge");
    reset = 1;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      if (tv[i].we) wr(tv[i].a, tv[i].d);
      rd(tv[i].a, tv[i].rd, $sformatf("tv%0d_rd", i));
      chk($sformatf("tv%0d_led", i), 64'(ledr), 64'(tv[i].led));
      chk($sformatf("tv%0d_hex", i), 64'(hex_digits), 64'(tv[i].hex));
      if (i == 1) chk("seg_digit0_F", 64'(hex_seg_n[6:0]), 64'(7'b0001110));
    end
    wr(32'h004, 32'h55);
    chk("no_io_write", 64'(ledr), 64'h12);
    chk("io_sel_low", 64'(io_sel), 0);
    for (int d = 0; d < 16; d++) begin
      wr(32'h108, {8'h0, {6{4'(d)}}});
      chk($sformatf("seg_%0h", d), 64'(hex_seg_n), 64'({6{seg_tab[d]}}));
    end
    key_n[1] = 0;
    cyc(5);
    rd(32'h110, 0, "key_early");
    cyc(1);
    rd(32'h110, 2, "key_latency");
    rd(32'h140, 2, "edge_set");
    key_n[0] = 0;
    cyc(3);
    key_n[0] = 1;
    cyc(8);
    rd(32'h110, 2, "glitch_key");
    rd(32'h140, 2, "glitch_edge");
    wr(32'h140, 2);
    rd(32'h140, 0, "w1c_clear");
    key_n[1] = 1;
    cyc(8);
    rd(32'h110, 0, "release_key");
    rd(32'h140, 0, "release_no_edge");
    key_n[1] = 0;
    cyc(5);
    wr(32'h140, 2);
    rd(32'h140, 2, "set_wins");
    rd(32'h110, 2, "repress_key");
    sw = 10'h2A5;
    cyc(1);
    rd(32'h120, 0, "sw_early");
    cyc(1);
    rd(32'h120, 32'h2A5, "sw_sync");
    wr(32'h120, 0);
    rd(32'h120, 32'h2A5, "sw_ro");
    wr(32'h104, 32'h2AA);
    chk("led_pre_rst", 64'(ledr), 64'h2AA);
    key_n[0] = 0;
    cyc(3);
    reset = 0;
    #1;
    chk("arst_led", 64'(ledr), 0);
    chk("arst_seg", 64'(hex_seg_n), 64'({6{7'b1000000}}));
    rd(32'h110, 0, "arst_key");
    rd(32'h140, 0, "arst_edge");
    rd(32'h120, 0, "arst_sw");
    key_n = '1;
    cyc(2);
    reset = 1;
    cyc(10);
    rd(32'h110, 0, "post_rst_key");
    rd(32'h140, 0, "post_rst_no_edge");
`ifdef MMIO_IO_IRQ_EN
    wr(32'h180, 1);
    rd(32'h180, 1, "mask_rd");
    chk("irq_idle", 64'(irq), 0);
    key_n[0] = 0;
    cyc(6);
    rd(32'h140, 1, "irq_edge");
    chk("irq_lag", 64'(irq), 0);
    cyc(1);
    chk("irq_set", 64'(irq), 1);
    wr(32'h140, 1);
    chk("irq_hold", 64'(irq), 1);
    cyc(1);
    chk("irq_drop", 64'(irq), 0);
    key_n[2] = 0;
    cyc(10);
    rd(32'h140, 4, "edge_key2");
    chk("irq_masked", 64'(irq), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
